up_down_counter_n: RTL and testbench
====================================

UP_DOWN_COUNTER_N -- requirements
Module: up_down_counter_n

Interface
REQ-001 Parameter: WIDTH, default 3, counter width in bits (SHALL be at least 2).
REQ-002 Parameter: MAX_VAL, default 2**WIDTH-1, inclusive upper count limit (SHALL be at least 1 and at most 2**WIDTH-1).
REQ-003 Parameter: SATURATE, default 0; 0 = wrap at limits, 1 = hold at limits.
REQ-004 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-005 Port: reset, input, 1, synchronous active-low reset sampled on the rising edge of clk.
REQ-006 Port: ld, input, 1, load request.
REQ-007 Port: data, input, WIDTH, load value.
REQ-008 Port: inc, input, 1, count-up request.
REQ-009 Port: dec, input, 1, count-down request.
REQ-010 Port: out, output, WIDTH, registered count.
REQ-011 Port: at_max, output, 1, combinational, high iff out == MAX_VAL.
REQ-012 Port: at_zero, output, 1, combinational, high iff out == 0.
REQ-013 Port: wrap, output, 1, registered one-cycle pulse marking a wrap event.
REQ-014 Port: sat, output, 1, registered sticky flag marking a blocked step in SATURATE=1 mode.
REQ-015 Port: ld_err, output, 1, registered one-cycle pulse marking an out-of-range load.

Function
REQ-016 Per-edge priority SHALL be: reset, then ld, then (inc and dec both high), then inc, then dec, then hold.
REQ-017 ld with data <= MAX_VAL: out SHALL take data on the next edge; ld_err SHALL be 0.
REQ-018 ld with data > MAX_VAL: out SHALL take MAX_VAL on the next edge; ld_err SHALL be 1 for exactly that cycle.
REQ-019 ld SHALL clear sat on the same edge; ld SHALL NOT assert wrap.
REQ-020 inc and dec both high without ld: out SHALL hold; wrap SHALL be 0.
REQ-021 inc with out < MAX_VAL: out SHALL become out+1.
REQ-022 dec with out > 0: out SHALL become out-1.
REQ-023 inc at MAX_VAL with SATURATE=0: out SHALL become 0 and wrap SHALL be 1 in the following cycle.
REQ-024 dec at 0 with SATURATE=0: out SHALL become MAX_VAL and wrap SHALL be 1 in the following cycle.
REQ-025 inc at MAX_VAL or dec at 0 with SATURATE=1: out SHALL hold, sat SHALL set and stay set until ld or reset; wrap SHALL remain 0.
REQ-026 wrap and ld_err SHALL be 0 in every cycle not caused by their triggering event (one-cycle pulses, no stretching).
REQ-027 All next-count arithmetic SHALL be WIDTH bits wide; out SHALL never exceed MAX_VAL.
REQ-028 Back-to-back wrap events SHALL produce wrap high on consecutive cycles.

Reset
REQ-029 With reset low at an edge: out = 0, wrap = 0, sat = 0, ld_err = 0; inputs ignored.
REQ-030 Reset asserted mid-count SHALL take effect on that edge; a pending wrap or ld_err pulse SHALL be suppressed.
REQ-031 The first edge after reset deasserts SHALL process inputs normally.

Structure
REQ-032 SATURATE mode encodings (MODE_WRAP = 0, MODE_SAT = 1) SHALL live in the shared package counter_pkg.
REQ-033 The block SHALL be a single module with no sub-module; next-state logic SHALL be one combinational function of out, ld, data, inc and dec, followed by one register stage.

Verification
REQ-034 Bench configuration SHALL be WIDTH=3, MAX_VAL=5, SATURATE=0 unless stated otherwise.
REQ-035 Reset, then inc for 6 cycles -> out sequence 1,2,3,4,5,0; wrap high only in the cycle out shows 0; at_max high while out = 5.
REQ-036 out = 0, dec for 1 cycle -> out = 5, wrap pulse for 1 cycle, at_zero low.
REQ-037 ld with data = 7 -> out = 5 and ld_err high for 1 cycle; then ld with data = 2 -> out = 2 and ld_err low.
REQ-038 SATURATE=1: load 5, inc for 3 cycles -> out stays 5, sat high and sticky, wrap never high; ld with data = 1 -> sat cleared, out = 1.
REQ-039 inc and dec high together at out = 3 -> out holds 3; reset low while inc is high at out = 5 -> out = 0 next cycle with no wrap pulse.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the counter family: limit behaviour selection and
// the per-edge operation chosen by the next-state logic.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_BOTH = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } op_e;

    // Resolve the per-edge request priority: ld, then inc+dec together, then inc, then dec.
    function automatic op_e pick_op(input logic ld, input logic inc, input logic dec);
        if (ld)
            return OP_LOAD;
        else if (inc && dec)
            return OP_BOTH;
        else if (inc)
            return OP_INC;
        else if (dec)
            return OP_DEC;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/up_down_counter_n.sv
// Bounded up/down counter with load, wrap-or-saturate limit handling and
// registered wrap / sticky-saturation / load-range-error flags.
module up_down_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [WIDTH-1:0] data,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             sat,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic             HOLD_AT_LIMIT = (SATURATE == MODE_SAT);

    op_e              op;
    logic [WIDTH-1:0] out_nxt;
    logic             wrap_nxt;
    logic             sat_nxt;
    logic             ld_err_nxt;

    always_comb begin
        op         = pick_op(ld, inc, dec);
        out_nxt    = out;
        wrap_nxt   = 1'b0;
        sat_nxt    = sat;
        ld_err_nxt = 1'b0;
        unique case (op)
            OP_LOAD: begin
                sat_nxt = 1'b0;
                // Out-of-range loads clamp to the limit so out never exceeds MAX_VAL.
                if (data > LIMIT) begin
                    out_nxt    = LIMIT;
                    ld_err_nxt = 1'b1;
                end else begin
                    out_nxt = data;
                end
            end
            OP_INC: begin
                if (out == LIMIT) begin
                    if (HOLD_AT_LIMIT) begin
                        sat_nxt = 1'b1;
                    end else begin
                        out_nxt  = ZERO;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    out_nxt = out + ONE;
                end
            end
            OP_DEC: begin
                if (out == ZERO) begin
                    if (HOLD_AT_LIMIT) begin
                        sat_nxt = 1'b1;
                    end else begin
                        out_nxt  = LIMIT;
                        wrap_nxt = 1'b1;
                    end
                end else begin
                    out_nxt = out - ONE;
                end
            end
            OP_BOTH, OP_HOLD: begin
                out_nxt = out;
            end
            default: begin
                out_nxt = out;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out    <= '0;
            wrap   <= 1'b0;
            sat    <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            out    <= out_nxt;
            wrap   <= wrap_nxt;
            sat    <= sat_nxt;
            ld_err <= ld_err_nxt;
        end
    end

    assign at_max  = (out == LIMIT);
    assign at_zero = (out == ZERO);

endmodule

// File: tb/tb_up_down_counter_n.sv
// Directed bench: a wrapping and a saturating counter (WIDTH=3, MAX_VAL=5)
// driven from shared inputs, outputs checked against hand-computed values.
module tb_up_down_counter_n;

    logic       clk;
    logic       reset;
    logic       ld;
    logic [2:0] data;
    logic       inc;
    logic       dec;

    logic [2:0] out_w, out_s;
    logic       at_max_w, at_zero_w, wrap_w, sat_w, ld_err_w;
    logic       at_max_s, at_zero_s, wrap_s, sat_s, ld_err_s;

    int n_checks = 0;
    int n_errors = 0;

    up_down_counter_n #(.WIDTH(3), .MAX_VAL(5), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .ld(ld), .data(data), .inc(inc), .dec(dec),
        .out(out_w), .at_max(at_max_w), .at_zero(at_zero_w),
        .wrap(wrap_w), .sat(sat_w), .ld_err(ld_err_w)
    );

    up_down_counter_n #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .ld(ld), .data(data), .inc(inc), .dec(dec),
        .out(out_s), .at_max(at_max_s), .at_zero(at_zero_s),
        .wrap(wrap_s), .sat(sat_s), .ld_err(ld_err_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs set after this are seen on the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic [2:0] d, input logic i, input logic de);
        ld   = l;
        data = d;
        inc  = i;
        dec  = de;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b1, 3'd3, 1'b1, 1'b0);
        tick();
        tick();
        chk("rst_out", out_w, 0);
        chk("rst_wrap", wrap_w, 0);
        chk("rst_sat", sat_w, 0);
        chk("rst_ld_err", ld_err_w, 0);
        chk("rst_at_zero", at_zero_w, 1);
        chk("rst_at_max", at_max_w, 0);

        // Count up through the limit: 1,2,3,4,5,0 with wrap only on 0.
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk($sformatf("up_out_%0d", k), out_w, k % 6);
            chk($sformatf("up_wrap_%0d", k), wrap_w, (k == 6) ? 1 : 0);
            chk($sformatf("up_at_max_%0d", k), at_max_w, (k == 5) ? 1 : 0);
        end

        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk("dn_wrap_out", out_w, 5);
        chk("dn_wrap_pulse", wrap_w, 1);
        chk("dn_wrap_at_zero", at_zero_w, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("wrap_no_stretch", wrap_w, 0);
        chk("hold_out", out_w, 5);

        // Back-to-back wraps: 5 -> 0 (inc), 0 -> 5 (dec).
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk("b2b_out_a", out_w, 0);
        chk("b2b_wrap_a", wrap_w, 1);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk("b2b_out_b", out_w, 5);
        chk("b2b_wrap_b", wrap_w, 1);

        // Load out of range clamps, then in-range load.
        drive(1'b1, 3'd7, 1'b1, 1'b0);
        tick();
        chk("ld7_out", out_w, 5);
        chk("ld7_err", ld_err_w, 1);
        chk("ld7_no_wrap", wrap_w, 0);
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        tick();
        chk("ld2_out", out_w, 2);
        chk("ld2_err", ld_err_w, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("ld_err_no_stretch", ld_err_w, 0);

        // inc and dec together hold.
        drive(1'b1, 3'd3, 1'b0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 1'b1, 1'b1);
        tick();
        chk("both_out", out_w, 3);
        chk("both_wrap", wrap_w, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk("dec_out", out_w, 2);

        // Reset at the limit while inc is high suppresses the wrap.
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        chk("pre_rst_out", out_w, 5);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        chk("midrst_out", out_w, 0);
        chk("midrst_wrap", wrap_w, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_out", out_w, 1);
        chk("post_rst_wrap", wrap_w, 0);

        // Saturating instance: blocked steps set a sticky flag, load clears it.
        drive(1'b1, 3'd5, 1'b0, 1'b0);
        tick();
        chk("s_ld5_out", out_s, 5);
        chk("s_ld5_sat", sat_s, 0);
        drive(1'b0, 3'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("s_inc_out_%0d", k), out_s, 5);
            chk($sformatf("s_inc_sat_%0d", k), sat_s, 1);
            chk($sformatf("s_inc_wrap_%0d", k), wrap_s, 0);
        end
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        chk("s_sticky", sat_s, 1);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        tick();
        chk("s_ld1_out", out_s, 1);
        chk("s_ld1_sat", sat_s, 0);
        drive(1'b0, 3'd0, 1'b0, 1'b1);
        tick();
        chk("s_dec_out", out_s, 0);
        chk("s_dec_sat", sat_s, 0);
        tick();
        chk("s_dec0_out", out_s, 0);
        chk("s_dec0_sat", sat_s, 1);
        chk("s_dec0_wrap", wrap_s, 0);
        reset = 1'b0;
        tick();
        chk("s_rst_sat", sat_s, 0);
        reset = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
